// File: rtl/mod_step_seq_checker.sv
// Receive-side sequence checker for mod-N step-by-STEP up/down counters.
// Locks onto the legal value ladder LO..HI, infers direction, flags wraps and illegal samples.
module mod_step_seq_checker #(
   parameter int W        = 8,
   parameter int STEP     = 7,
   parameter int LO       = 7,
   parameter int HI       = 203,
   parameter int LOCK_CNT = 3,
   parameter int ERR_W    = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             valid_i,
   input  logic [W-1:0]     value_i,
   output logic             locked_o,
   output logic             dir_o,
   output logic             wrap_pulse_o,
   output logic             err_pulse_o,
   output logic [ERR_W-1:0] err_count_o,
   output logic [W-1:0]     expected_o
);

   localparam int CW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
   localparam logic [W:0]    LO_X   = (W+1)'(LO);
   localparam logic [W:0]    HI_X   = (W+1)'(HI);
   localparam logic [W:0]    STEP_X = (W+1)'(STEP);
   localparam logic [CW-1:0] LOCK_X = CW'(LOCK_CNT);

   typedef enum logic [1:0] {HUNT, FIRST, TRACK, LOCKED} state_t;

   state_t            state_q, state_d;
   logic [W-1:0]      ref_q, ref_d;
   logic              dir_q, dir_d;
   logic [CW-1:0]     match_q, match_d;
   logic              locked_q, locked_d;
   logic              wrap_q, wrap_d;
   logic              err_q, err_d;
   logic [ERR_W-1:0]  errcnt_q, errcnt_d;
   logic [W-1:0]      exp_q, exp_d;

   logic              up_m, dn_m, fwd_m, rev_m, val_legal, wrap_c;
   logic [CW-1:0]     match_inc;

   // All arithmetic is done one bit wider so no W-bit overflow can alias a legal value.
   function automatic logic is_legal(input logic [W-1:0] v);
      logic [W:0] vx;
      logic [W:0] d;
      vx = {1'b0, v};
      d  = vx - LO_X;
      return (vx >= LO_X) && (vx <= HI_X) && ((d % STEP_X) == '0);
   endfunction

   function automatic logic [W-1:0] up_of(input logic [W-1:0] r);
      logic [W:0] s;
      s = ({1'b0, r} == HI_X) ? LO_X : ({1'b0, r} + STEP_X);
      return s[W-1:0];
   endfunction

   function automatic logic [W-1:0] dn_of(input logic [W-1:0] r);
      logic [W:0] s;
      s = ({1'b0, r} == LO_X) ? HI_X : ({1'b0, r} - STEP_X);
      return s[W-1:0];
   endfunction

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= HUNT;
         ref_q    <= '0;
         dir_q    <= 1'b1;
         match_q  <= '0;
         locked_q <= 1'b0;
         wrap_q   <= 1'b0;
         err_q    <= 1'b0;
         errcnt_q <= '0;
         exp_q    <= '0;
      end else begin
         state_q  <= state_d;
         ref_q    <= ref_d;
         dir_q    <= dir_d;
         match_q  <= match_d;
         locked_q <= locked_d;
         wrap_q   <= wrap_d;
         err_q    <= err_d;
         errcnt_q <= errcnt_d;
         exp_q    <= exp_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ref_d     = ref_q;
      dir_d     = dir_q;
      match_d   = match_q;
      locked_d  = locked_q;
      wrap_d    = 1'b0;
      err_d     = 1'b0;
      errcnt_d  = errcnt_q;
      exp_d     = exp_q;

      up_m      = (value_i == up_of(ref_q));
      dn_m      = (value_i == dn_of(ref_q));
      fwd_m     = dir_q ? up_m : dn_m;
      rev_m     = dir_q ? dn_m : up_m;
      val_legal = is_legal(value_i);
      wrap_c    = (up_m && ({1'b0, ref_q} == HI_X)) || (dn_m && ({1'b0, ref_q} == LO_X));
      match_inc = match_q + 1'b1;

      if (valid_i) begin
         unique case (state_q)
            HUNT: begin
               if (val_legal) begin
                  ref_d   = value_i;
                  state_d = FIRST;
               end
            end
            FIRST: begin
               if (up_m || dn_m) begin
                  dir_d    = up_m;
                  match_d  = CW'(1);
                  ref_d    = value_i;
                  state_d  = (CW'(1) >= LOCK_X) ? LOCKED : TRACK;
                  locked_d = (CW'(1) >= LOCK_X);
               end else if (val_legal) begin
                  ref_d = value_i;
               end else begin
                  state_d = HUNT;
               end
            end
            TRACK: begin
               if (fwd_m || rev_m) begin
                  match_d  = fwd_m ? match_inc : CW'(1);
                  dir_d    = up_m;
                  ref_d    = value_i;
                  wrap_d   = wrap_c;
                  if ((fwd_m ? match_inc : CW'(1)) >= LOCK_X) begin
                     state_d  = LOCKED;
                     locked_d = 1'b1;
                  end
               end else begin
                  match_d = '0;
                  if (val_legal) begin
                     ref_d   = value_i;
                     state_d = FIRST;
                  end else begin
                     state_d = HUNT;
                  end
               end
            end
            LOCKED: begin
               if (up_m || dn_m) begin
                  dir_d  = up_m;
                  ref_d  = value_i;
                  wrap_d = wrap_c;
               end else begin
                  err_d    = 1'b1;
                  errcnt_d = (errcnt_q == '1) ? errcnt_q : errcnt_q + 1'b1;
                  locked_d = 1'b0;
                  match_d  = '0;
                  if (val_legal) begin
                     ref_d   = value_i;
                     state_d = FIRST;
                  end else begin
                     state_d = HUNT;
                  end
               end
            end
            default: state_d = HUNT;
         endcase
         exp_d = dir_d ? up_of(ref_d) : dn_of(ref_d);
      end
   end

   assign locked_o     = locked_q;
   assign dir_o        = dir_q;
   assign wrap_pulse_o = wrap_q;
   assign err_pulse_o  = err_q;
   assign err_count_o  = errcnt_q;
   assign expected_o   = exp_q;

endmodule

// File: tb/tb_mod_step_seq_checker.sv
// Directed-vector bench for mod_step_seq_checker (W=8, STEP=7, LO=7, HI=203, LOCK_CNT=3).
module tb_mod_step_seq_checker;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic       valid_i;
   logic [7:0] value_i;
   logic       locked_o, dir_o, wrap_pulse_o, err_pulse_o;
   logic [7:0] err_count_o, expected_o;

   int n_vec = 0;
   int n_bad = 0;

   mod_step_seq_checker dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .value_i(value_i),
      .locked_o(locked_o), .dir_o(dir_o), .wrap_pulse_o(wrap_pulse_o),
      .err_pulse_o(err_pulse_o), .err_count_o(err_count_o), .expected_o(expected_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic apply(input int v);
      @(negedge clk_i);
      valid_i = 1'b1;
      value_i = 8'(v);
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
   endtask

   task automatic idle();
      @(negedge clk_i);
      valid_i = 1'b0;
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_ni  = 1'b0;
      valid_i = 1'b0;
      value_i = '0;
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_vec++;
      if ({locked_o, dir_o, wrap_pulse_o, err_pulse_o} !== 4'b0100 || err_count_o !== 8'd0 || expected_o !== 8'd0) begin
         n_bad++;
         $display("FAIL reset: got locked=%b dir=%b wrap=%b err=%b cnt=%0d exp=%0d, want 0 1 0 0 0 0",
                  locked_o, dir_o, wrap_pulse_o, err_pulse_o, err_count_o, expected_o);
      end
   endtask

   task automatic test_lock_up();
      apply(7); apply(14); apply(21);
      n_vec++;
      if (locked_o !== 1'b0) begin
         n_bad++; $display("FAIL lock_early: locked=%b want 0", locked_o);
      end
      apply(28);
      n_vec++;
      if (locked_o !== 1'b1 || dir_o !== 1'b1 || expected_o !== 8'd35) begin
         n_bad++; $display("FAIL lock_up: locked=%b dir=%b exp=%0d want 1 1 35", locked_o, dir_o, expected_o);
      end
   endtask

   task automatic test_wrap_up();
      for (int v = 35; v <= 196; v += 7) apply(v);
      apply(203);
      n_vec++;
      if (wrap_pulse_o !== 1'b0 || expected_o !== 8'd7) begin
         n_bad++; $display("FAIL wrap_up_pre: wrap=%b exp=%0d want 0 7", wrap_pulse_o, expected_o);
      end
      apply(7);
      n_vec++;
      if (wrap_pulse_o !== 1'b1 || err_pulse_o !== 1'b0 || dir_o !== 1'b1) begin
         n_bad++; $display("FAIL wrap_up: wrap=%b err=%b dir=%b want 1 0 1", wrap_pulse_o, err_pulse_o, dir_o);
      end
      apply(14);
      n_vec++;
      if (wrap_pulse_o !== 1'b0 || expected_o !== 8'd21 || err_count_o !== 8'd0 || locked_o !== 1'b1) begin
         n_bad++; $display("FAIL wrap_up_post: wrap=%b exp=%0d cnt=%0d locked=%b want 0 21 0 1",
                           wrap_pulse_o, expected_o, err_count_o, locked_o);
      end
   endtask

   task automatic test_wrap_down();
      apply(7);
      n_vec++;
      if (dir_o !== 1'b0 || wrap_pulse_o !== 1'b0 || expected_o !== 8'd203) begin
         n_bad++; $display("FAIL dir_flip: dir=%b wrap=%b exp=%0d want 0 0 203", dir_o, wrap_pulse_o, expected_o);
      end
      apply(203);
      n_vec++;
      if (wrap_pulse_o !== 1'b1 || expected_o !== 8'd196 || err_pulse_o !== 1'b0) begin
         n_bad++; $display("FAIL wrap_down: wrap=%b exp=%0d err=%b want 1 196 0", wrap_pulse_o, expected_o, err_pulse_o);
      end
      apply(196);
      n_vec++;
      if (wrap_pulse_o !== 1'b0 || expected_o !== 8'd189 || err_count_o !== 8'd0 || locked_o !== 1'b1) begin
         n_bad++; $display("FAIL wrap_down_post: wrap=%b exp=%0d cnt=%0d locked=%b want 0 189 0 1",
                           wrap_pulse_o, expected_o, err_count_o, locked_o);
      end
   endtask

   task automatic test_error_relock();
      do_reset();
      apply(49); apply(56); apply(63); apply(70);
      n_vec++;
      if (locked_o !== 1'b1) begin
         n_bad++; $display("FAIL lock_70: locked=%b want 1", locked_o);
      end
      apply(80);
      n_vec++;
      if (err_pulse_o !== 1'b1 || err_count_o !== 8'd1 || locked_o !== 1'b0) begin
         n_bad++; $display("FAIL err_inject: err=%b cnt=%0d locked=%b want 1 1 0", err_pulse_o, err_count_o, locked_o);
      end
      apply(84); apply(91); apply(98);
      n_vec++;
      if (locked_o !== 1'b0 || err_pulse_o !== 1'b0) begin
         n_bad++; $display("FAIL relock_early: locked=%b err=%b want 0 0", locked_o, err_pulse_o);
      end
      apply(105);
      n_vec++;
      if (locked_o !== 1'b1 || dir_o !== 1'b1 || expected_o !== 8'd112 || err_count_o !== 8'd1) begin
         n_bad++; $display("FAIL relock: locked=%b dir=%b exp=%0d cnt=%0d want 1 1 112 1",
                           locked_o, dir_o, expected_o, err_count_o);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      apply(7); apply(14); apply(21); apply(28);
      for (int i = 1; i <= 300; i++) begin
         apply(42);
         if (i == 1 || i == 254 || i == 255 || i == 300) begin
            n_vec++;
            if (err_pulse_o !== 1'b1 || err_count_o !== 8'((i > 255) ? 255 : i)) begin
               n_bad++; $display("FAIL sat_%0d: err=%b cnt=%0d want 1 %0d", i, err_pulse_o, err_count_o,
                                 (i > 255) ? 255 : i);
            end
         end
         apply(7); apply(14); apply(21); apply(28);
      end
      apply(35);
      @(negedge clk_i);
      valid_i = 1'b1;
      value_i = 8'd99;
      rst_ni  = 1'b0;
      #1;
      n_vec++;
      if ({locked_o, dir_o, wrap_pulse_o, err_pulse_o} !== 4'b0100 || err_count_o !== 8'd0 || expected_o !== 8'd0) begin
         n_bad++;
         $display("FAIL async_reset: got locked=%b dir=%b wrap=%b err=%b cnt=%0d exp=%0d, want 0 1 0 0 0 0",
                  locked_o, dir_o, wrap_pulse_o, err_pulse_o, err_count_o, expected_o);
      end
      valid_i = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   task automatic test_valid_gaps();
      do_reset();
      apply(7); apply(14); apply(21); apply(28); apply(35); apply(42);
      for (int i = 0; i < 3; i++) begin
         idle();
         n_vec++;
         if (locked_o !== 1'b1 || wrap_pulse_o !== 1'b0 || err_pulse_o !== 1'b0 || expected_o !== 8'd49) begin
            n_bad++; $display("FAIL gap_%0d: locked=%b wrap=%b err=%b exp=%0d want 1 0 0 49",
                              i, locked_o, wrap_pulse_o, err_pulse_o, expected_o);
         end
      end
      apply(49);
      n_vec++;
      if (locked_o !== 1'b1 || err_pulse_o !== 1'b0 || err_count_o !== 8'd0 || expected_o !== 8'd56) begin
         n_bad++; $display("FAIL gap_resume: locked=%b err=%b cnt=%0d exp=%0d want 1 0 0 56",
                           locked_o, err_pulse_o, err_count_o, expected_o);
      end
   endtask

   initial begin
      rst_ni  = 1'b1;
      valid_i = 1'b0;
      value_i = '0;
      test_reset();
      test_lock_up();
      test_wrap_up();
      test_wrap_down();
      test_error_relock();
      test_saturation();
      test_valid_gaps();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
